fibo_sequencer: RTL and testbench

//  Requester for the fibonacci calculator's begin_fibo/done interface: sweeps index range

---
 rtl/fibo_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fibo_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_sequencer.sv
// Sweeps an index range through the fibonacci calculator, one request per index,
// and queues each {index, result} pair in a first-word-fall-through result FIFO.
module fibo_sequencer #(
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    output logic              busy,
    output logic              seq_done,
    output logic              error,
    output logic              begin_fibo,
    output logic [IDX_W-1:0]  input_s,
    input  logic [DATA_W-1:0] fibo_out,
    input  logic              done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [DATA_W-1:0] res_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              busy_q, busy_d;
    logic              seq_done_q, seq_done_d;
    logic              error_q, error_d;
    logic              begin_fibo_q, begin_fibo_d;
    logic [IDX_W-1:0]  input_s_q, input_s_d;

    logic [IDX_W-1:0]  idx_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              fifo_full;
    logic              push;
    logic              pop;

    assign fifo_full = (count_q == CW'(DEPTH));
    assign res_valid = (count_q != '0);
    assign pop       = res_valid & res_ready;
    assign res_idx   = res_valid ? idx_mem_q[rd_ptr_q]  : '0;
    assign res_data  = res_valid ? data_mem_q[rd_ptr_q] : '0;

    assign busy       = busy_q;
    assign seq_done   = seq_done_q;
    assign error      = error_q;
    assign begin_fibo = begin_fibo_q;
    assign input_s    = input_s_q;

    // A FIFO slot is reserved before each request goes out, so the later push can never overflow.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_d       = last_q;
        timer_d      = timer_q;
        error_d      = error_q;
        input_s_d    = input_s_q;
        seq_done_d   = 1'b0;
        begin_fibo_d = 1'b0;
        push         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (first_idx <= last_idx) begin
                        cur_d   = first_idx;
                        last_d  = last_idx;
                        state_d = S_ISSUE;
                    end else begin
                        seq_done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!fifo_full) begin
                    begin_fibo_d = 1'b1;
                    input_s_d    = cur_q;
                    timer_d      = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    push = 1'b1;
                    if (cur_q == last_q) begin
                        seq_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    seq_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            last_q       <= '0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            seq_done_q   <= 1'b0;
            error_q      <= 1'b0;
            begin_fibo_q <= 1'b0;
            input_s_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            timer_q      <= timer_d;
            busy_q       <= busy_d;
            seq_done_q   <= seq_done_d;
            error_q      <= error_d;
            begin_fibo_q <= begin_fibo_d;
            input_s_q    <= input_s_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while the occupancy count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem_q[wr_ptr_q]  <= cur_q;
            data_mem_q[wr_ptr_q] <= fibo_out;
        end
    end

endmodule

// File: tb/tb_fibo_sequencer.sv
// Directed bench for fibo_sequencer: a delayed-response calculator model feeds the DUT
// and a queue of expected {index, fibonacci} entries is checked as the FIFO drains.
module tb_fibo_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic        busy;
    logic        seq_done;
    logic        error;
    logic        begin_fibo;
    logic [4:0]  input_s;
    logic [15:0] fibo_out;
    logic        done;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_idx;
    logic [15:0] res_data;

    typedef struct {
        int idx;
        int data;
    } entry_t;

    entry_t sbQ[$];
    int     checks    = 0;
    int     errors    = 0;
    int     doneCnt   = 0;
    int     beginCnt  = 0;
    bit     peerEnable = 1'b1;
    int     peerDelay = 0;
    int     peerIdx   = 0;

    fibo_sequencer #(
        .IDX_W  (5),
        .DATA_W (16),
        .DEPTH  (8),
        .TIMEOUT(64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .busy      (busy),
        .seq_done  (seq_done),
        .error     (error),
        .begin_fibo(begin_fibo),
        .input_s   (input_s),
        .fibo_out  (fibo_out),
        .done      (done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx),
        .res_data  (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] fibRef(input int n);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Calculator model: answers three cycles after seeing a request, even across a DUT reset.
    always @(negedge clk) begin
        done     = 1'b0;
        fibo_out = 16'd0;
        if (peerDelay > 0) begin
            peerDelay--;
            if (peerDelay == 0) begin
                done     = 1'b1;
                fibo_out = fibRef(peerIdx);
            end
        end else if (begin_fibo === 1'b1 && peerEnable) begin
            peerIdx   = int'(input_s);
            peerDelay = 3;
        end
    end

    always @(negedge clk) begin
        entry_t e;
        if (reset_n) begin
            if (seq_done === 1'b1) doneCnt++;
            if (begin_fibo === 1'b1) beginCnt++;
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                checks++;
                assert (sbQ.size() > 0) else begin
                    errors++;
                    $error("FAIL pop_unexpected: observed idx %0d data %0d, expected no entry", res_idx, res_data);
                end
                if (sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    checks++;
                    assert (int'(res_idx) === e.idx) else begin
                        errors++;
                        $error("FAIL res_idx: observed %0d expected %0d", res_idx, e.idx);
                    end
                    checks++;
                    assert (int'(res_data) === e.data) else begin
                        errors++;
                        $error("FAIL res_data[%0d]: observed %0d expected %0d", e.idx, res_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int f, input int l);
        start     = 1'b1;
        first_idx = 5'(f);
        last_idx  = 5'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic expectRange(input int f, input int l);
        for (int i = f; i <= l; i++) begin
            sbQ.push_back('{i, int'(fibRef(i))});
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, int'(busy), 0);
    endtask

    task automatic waitBegin(input string tag, input int budget);
        int n = 0;
        while (begin_fibo !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, int'(begin_fibo), 1);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        first_idx = 5'd0;
        last_idx  = 5'd0;
        res_ready = 1'b0;
        repeat (3) tick();

        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_seq_done", int'(seq_done), 0);
        checkOutput("rst_error", int'(error), 0);
        checkOutput("rst_begin_fibo", int'(begin_fibo), 0);
        checkOutput("rst_input_s", int'(input_s), 0);
        checkOutput("rst_res_valid", int'(res_valid), 0);
        checkOutput("rst_res_idx", int'(res_idx), 0);
        checkOutput("rst_res_data", int'(res_data), 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] sweep 1..5 with free-running consumer");
        res_ready = 1'b1;
        doneCnt   = 0;
        beginCnt  = 0;
        expectRange(1, 5);
        applyStimulus(1, 5);
        checkOutput("t1_busy_start", int'(busy), 1);
        waitIdle("t1_idle", 200);
        repeat (3) tick();
        checkOutput("t1_seq_done_count", doneCnt, 1);
        checkOutput("t1_begin_count", beginCnt, 5);
        checkOutput("t1_queue_left", sbQ.size(), 0);
        checkOutput("t1_error", int'(error), 0);

        $display("[TB] sweep 0..10 against a stalled consumer");
        res_ready = 1'b0;
        doneCnt   = 0;
        beginCnt  = 0;
        expectRange(0, 10);
        applyStimulus(0, 10);
        repeat (80) tick();
        checkOutput("t2_full_valid", int'(res_valid), 1);
        checkOutput("t2_full_busy", int'(busy), 1);
        checkOutput("t2_full_begins", beginCnt, 8);
        checkOutput("t2_head_idx", int'(res_idx), 0);
        repeat (20) tick();
        checkOutput("t2_still_held", beginCnt, 8);
        checkOutput("t2_no_done", doneCnt, 0);
        res_ready = 1'b1;
        waitIdle("t2_idle", 300);
        repeat (3) tick();
        checkOutput("t2_seq_done_count", doneCnt, 1);
        checkOutput("t2_begin_count", beginCnt, 11);
        checkOutput("t2_queue_left", sbQ.size(), 0);

        $display("[TB] silent calculator times out");
        peerEnable = 1'b0;
        doneCnt    = 0;
        applyStimulus(2, 4);
        waitBegin("t3_begin", 10);
        checkOutput("t3_input_s", int'(input_s), 2);
        repeat (63) tick();
        checkOutput("t3_error_before", int'(error), 0);
        checkOutput("t3_busy_before", int'(busy), 1);
        tick();
        checkOutput("t3_error_set", int'(error), 1);
        checkOutput("t3_seq_done", int'(seq_done), 1);
        checkOutput("t3_busy_clear", int'(busy), 0);
        tick();
        checkOutput("t3_seq_done_pulse", int'(seq_done), 0);
        checkOutput("t3_error_sticky", int'(error), 1);
        checkOutput("t3_res_valid", int'(res_valid), 0);
        peerEnable = 1'b1;
        expectRange(3, 3);
        applyStimulus(3, 3);
        checkOutput("t3_error_cleared", int'(error), 0);
        waitIdle("t3_idle", 100);
        repeat (3) tick();
        checkOutput("t3_queue_left", sbQ.size(), 0);

        $display("[TB] empty range 7..3");
        doneCnt  = 0;
        beginCnt = 0;
        applyStimulus(7, 3);
        checkOutput("t4_seq_done", int'(seq_done), 1);
        checkOutput("t4_busy", int'(busy), 0);
        tick();
        checkOutput("t4_seq_done_pulse", int'(seq_done), 0);
        repeat (5) tick();
        checkOutput("t4_begin_count", beginCnt, 0);
        checkOutput("t4_done_count", doneCnt, 1);

        $display("[TB] reset during WAIT with a late response");
        res_ready = 1'b0;
        applyStimulus(4, 6);
        waitBegin("t5_begin_a", 10);
        tick();
        waitBegin("t5_begin_b", 20);
        checkOutput("t5_fifo_loaded", int'(res_valid), 1);
        reset_n = 1'b0;
        tick();
        checkOutput("t5_busy", int'(busy), 0);
        checkOutput("t5_begin_fibo", int'(begin_fibo), 0);
        checkOutput("t5_input_s", int'(input_s), 0);
        checkOutput("t5_res_valid", int'(res_valid), 0);
        checkOutput("t5_res_idx", int'(res_idx), 0);
        checkOutput("t5_res_data", int'(res_data), 0);
        reset_n  = 1'b1;
        doneCnt  = 0;
        beginCnt = 0;
        res_ready = 1'b1;
        repeat (8) tick();
        checkOutput("t5_late_done_busy", int'(busy), 0);
        checkOutput("t5_late_done_fifo", int'(res_valid), 0);
        checkOutput("t5_late_done_begins", beginCnt, 0);
        checkOutput("t5_late_done_seq", doneCnt, 0);

        $display("[TB] restart attempt mid-sweep is ignored");
        doneCnt  = 0;
        beginCnt = 0;
        expectRange(2, 6);
        applyStimulus(2, 6);
        repeat (10) tick();
        applyStimulus(20, 22);
        waitIdle("t6_idle", 200);
        repeat (3) tick();
        checkOutput("t6_seq_done_count", doneCnt, 1);
        checkOutput("t6_begin_count", beginCnt, 5);
        checkOutput("t6_queue_left", sbQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
